mcp3002_reader: RTL and testbench

Upstream sample source for the UART link: on a one-cycle `start` request it runs one SPI conversion frame against an MCP3002 10-bit ADC and returns the result. It drives the `adc_clk`, `adc_din` and `adc_cs` pins and reads `adc_dout`. The 10-bit result appears on `sample` with a one-cycle `valid` pulse, for the control FSM to serialise into `uart_tx`.

---
 rtl/mcp3002_reader.sv | 114 +++++++++++
 tb/tb_mcp3002_reader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mcp3002_reader.sv
// MCP3002 SPI reader: one 16-clock mode-0 frame per accepted start, returning a
// 10-bit sample with a one-cycle valid pulse.
module mcp3002_reader #(
  parameter int CLK_FREQ     = 27_000_000,
  parameter int SPI_CLK_FREQ = 900_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       channel,
  output logic [9:0] sample,
  output logic       valid,
  output logic       busy,
  output logic       adc_cs,
  output logic       adc_clk,
  output logic       adc_din,
  input  logic       adc_dout,
  output logic [1:0] state_dbg
);

  localparam int HALF = CLK_FREQ / (2 * SPI_CLK_FREQ);
  localparam int CW   = $clog2(HALF) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(HALF - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, HOLD} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   sh_out;
  logic [9:0]    capture;
  logic          phase_done;
  logic [15:0]   cmd;

  assign phase_done = (cnt == '0);
  assign cmd        = {1'b0, 1'b1, 1'b1, channel, 1'b1, 11'b0};
  assign busy       = (state != IDLE);
  assign adc_din    = sh_out[15];
  assign state_dbg  = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = LOW;
      LOW:  if (phase_done) state_next = HIGH;
      HIGH: if (phase_done) state_next = (bit_cnt == 4'd15) ? HOLD : LOW;
      HOLD: if (phase_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Only the last ten captured bits (B9..B0) are kept; earlier bits fall off the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
      sh_out  <= '0;
      capture <= '0;
      sample  <= '0;
      valid   <= 1'b0;
      adc_cs  <= 1'b1;
      adc_clk <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_out  <= cmd;
            bit_cnt <= '0;
            cnt     <= RELOAD;
            adc_cs  <= 1'b0;
            adc_clk <= 1'b0;
          end
        end
        LOW: begin
          if (phase_done) begin
            cnt     <= RELOAD;
            adc_clk <= 1'b1;
            capture <= {capture[8:0], adc_dout};
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HIGH: begin
          if (phase_done) begin
            cnt     <= RELOAD;
            adc_clk <= 1'b0;
            if (bit_cnt == 4'd15) begin
              adc_cs <= 1'b1;
              sh_out <= '0;
              sample <= capture;
              valid  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sh_out  <= {sh_out[14:0], 1'b0};
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (!phase_done) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcp3002_reader.sv
// Directed bench for mcp3002_reader with a behavioural MCP3002 model and SPI
// waveform measurement, at the default 27 MHz / 900 kHz (HALF = 15).
module tb_mcp3002_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       channel;
  logic [9:0] sample;
  logic       valid;
  logic       busy;
  logic       adc_cs;
  logic       adc_clk;
  logic       adc_din;
  logic       adc_dout;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  mcp3002_reader dut (
    .clk(clk), .rst(rst), .start(start), .channel(channel),
    .sample(sample), .valid(valid), .busy(busy),
    .adc_cs(adc_cs), .adc_clk(adc_clk), .adc_din(adc_din),
    .adc_dout(adc_dout), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  logic [15:0] model_val = '0;
  logic [15:0] din_word;
  int fall_cnt = 0;
  int rise_cnt, last_rise, per_bad, high_bad;
  int cs_first, cs_last, edge_cs, valid_cnt, valid_rel;
  int idle_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    rise_cnt  = 0;
    last_rise = 0;
    per_bad   = 0;
    high_bad  = 0;
    cs_first  = -1;
    cs_last   = -1;
    edge_cs   = 0;
    valid_cnt = 0;
    valid_rel = -1;
    din_word  = '0;
  endtask

  // Advance one cycle, then observe the SPI pins and play the ADC role.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_cs && adc_cs && (adc_clk !== prev_sclk)) edge_cs++;
    if (!prev_sclk && adc_clk) begin
      if (rise_cnt > 0 && (cyc - last_rise) != 30) per_bad++;
      rise_cnt++;
      last_rise = cyc;
      din_word  = {din_word[14:0], adc_din};
    end
    if (prev_sclk && !adc_clk) begin
      if ((cyc - last_rise) != 15) high_bad++;
      if (!adc_cs) fall_cnt++;
    end
    if (adc_cs) begin
      fall_cnt = 0;
      adc_dout = 1'b0;
    end else if (fall_cnt >= 6 && fall_cnt <= 15) begin
      adc_dout = model_val[15 - fall_cnt];
    end else begin
      adc_dout = 1'b0;
    end
    if (!adc_cs) begin
      if (cs_first < 0) cs_first = cyc - t0;
      cs_last = cyc - t0;
    end
    if (valid) begin
      valid_cnt++;
      valid_rel = cyc - t0;
    end
    prev_sclk = adc_clk;
    prev_cs   = adc_cs;
  endtask

  task automatic begin_frame(input logic ch, input logic [15:0] val);
    channel   = ch;
    model_val = val;
    start     = 1'b1;
    t0        = cyc;
    clear_stats();
    tick();
    start = 1'b0;
  endtask

  task automatic goto(input int rel);
    while (cyc < t0 + rel) tick();
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    channel  = 1'b0;
    adc_dout = 1'b0;
    clear_stats();

    // Reset
    repeat (3) tick();
    check("rst_cs", adc_cs, 1);
    check("rst_clk", adc_clk, 0);
    check("rst_din", adc_din, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_sample", sample, 0);
    rst = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (adc_cs !== 1'b1 || adc_clk !== 1'b0 || busy !== 1'b0) idle_bad++;
    end
    check("idle_pins", idle_bad, 0);

    // CH0 conversion returning 0x2A5
    begin_frame(1'b0, 16'h02A5);
    check("f1_t1_busy", busy, 1);
    check("f1_t1_cs", adc_cs, 0);
    check("f1_t1_din", adc_din, 0);
    check("f1_t1_clk", adc_clk, 0);
    goto(15);
    check("f1_t15_clk", adc_clk, 0);
    goto(16);
    check("f1_t16_clk", adc_clk, 1);
    goto(481);
    check("f1_t481_valid", valid, 1);
    check("f1_t481_sample", sample, 10'h2A5);
    check("f1_t481_cs", adc_cs, 1);
    check("f1_t481_clk", adc_clk, 0);
    goto(482);
    check("f1_t482_valid", valid, 0);
    goto(495);
    check("f1_t495_busy", busy, 1);
    goto(496);
    check("f1_t496_busy", busy, 0);
    check("f1_din_word", din_word, 16'h6800);
    check("f1_rises", rise_cnt, 16);
    check("f1_period_bad", per_bad, 0);
    check("f1_high_bad", high_bad, 0);
    check("f1_cs_first", cs_first, 1);
    check("f1_cs_last", cs_last, 480);
    check("f1_edge_cs", edge_cs, 0);
    check("f1_valid_cnt", valid_cnt, 1);
    check("f1_valid_rel", valid_rel, 481);
    repeat (10) tick();

    // Reset mid-frame, previous sample 0x2A5 must be cleared
    begin_frame(1'b0, 16'h0155);
    goto(200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_cs", adc_cs, 1);
    check("abort_clk", adc_clk, 0);
    check("abort_busy", busy, 0);
    check("abort_sample", sample, 0);
    goto(700);
    check("abort_no_valid", valid_cnt, 0);
    check("abort_sample_held", sample, 0);
    check("abort_edge_cs", edge_cs, 0);

    // CH1 full scale, with starts while busy that must be ignored
    begin_frame(1'b1, 16'h03FF);
    goto(100);
    start = 1'b1;
    tick();
    start = 1'b0;
    goto(495);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("f2_t496_busy", busy, 0);
    check("f2_sample", sample, 10'h3FF);
    check("f2_din_word", din_word, 16'h7800);
    check("f2_rises", rise_cnt, 16);
    check("f2_valid_cnt", valid_cnt, 1);
    check("f2_valid_rel", valid_rel, 481);

    // Back-to-back start at T+496, CH1 returning zero
    begin_frame(1'b1, 16'h0000);
    check("f3_t1_cs", adc_cs, 0);
    check("f3_t1_busy", busy, 1);
    goto(481);
    check("f3_valid", valid, 1);
    check("f3_sample", sample, 10'h000);
    check("f3_din_word", din_word, 16'h7800);
    goto(496);
    check("f3_busy_end", busy, 0);
    check("f3_valid_cnt", valid_cnt, 1);
    check("f3_edge_cs", edge_cs, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
